// File: rtl/trng_collector_pkg.sv
// Shared types and default parameters for the TRNG collector.
// Holds the FSM state encoding used by the collector and its bench.
package trng_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COLLECT = 2'd2,
    ST_FAIL    = 2'd3
  } state_e;

  localparam int unsigned DEF_WORD_WIDTH    = 32;
  localparam int unsigned DEF_WARMUP_CYCLES = 16;
  localparam int unsigned DEF_REP_LIMIT     = 32;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs raw bits (first, second); 10 emits 1, 01 emits 0.
// The emitted value is the first bit of a differing pair.
module trng_vn_debias (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic sample_i,
  input  logic bit_i,
  output logic emit_o,
  output logic bit_o
);

  logic have_first_q, have_first_d;
  logic first_q, first_d;

  always_comb begin
    have_first_d = have_first_q;
    first_d      = first_q;
    if (clr_i) begin
      have_first_d = 1'b0;
      first_d      = 1'b0;
    end else if (sample_i) begin
      if (have_first_q) begin
        have_first_d = 1'b0;
      end else begin
        have_first_d = 1'b1;
        first_d      = bit_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_first_q <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      have_first_q <= have_first_d;
      first_q      <= first_d;
    end
  end

  assign emit_o = sample_i && !clr_i && have_first_q && (first_q != bit_i);
  assign bit_o  = first_q;

endmodule

// File: rtl/trng_collector.sv
// Collects debiased TRNG bits into words with warmup, repetition-count health
// test and a one-word skid (held word) behind the valid/ready output register.
module trng_collector
  import trng_collector_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int unsigned REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  trng_en,
  input  logic                  trng_in,
  input  logic                  clear_fail,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  health_fail
);

  localparam int unsigned      CNT_W    = $clog2(WORD_WIDTH + 1);
  localparam int unsigned      WARM_W   = $clog2(WARMUP_CYCLES + 2);
  localparam logic [7:0]       REP_MAX  = 8'(REP_LIMIT);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  state_e                  state_q, state_d;
  logic                    trng_en_q, trng_en_d;
  logic                    health_q, health_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic [WORD_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [WORD_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WARM_W-1:0]       warm_cnt_q, warm_cnt_d;
  logic [7:0]              rep_cnt_q, rep_cnt_d;
  logic                    last_bit_q, last_bit_d;

  logic                    active, rep_trip, out_free, sample, warm_done;
  logic                    db_clr, db_emit, db_bit;
  logic [7:0]              rep_inc;
  logic [WORD_WIDTH-1:0]   word;

  assign active    = enable && (state_q == ST_WARMUP || state_q == ST_COLLECT);
  assign rep_trip  = active && (rep_inc == REP_MAX);
  assign out_free  = !valid_q || ready_i;
  assign sample    = active && (state_q == ST_COLLECT) && !rep_trip && !hold_valid_q;
  assign db_clr    = !active || rep_trip;
  assign warm_done = (32'(warm_cnt_q) + 32'd1) >= WARMUP_CYCLES;
  assign word      = {shift_q[WORD_WIDTH-2:0], db_bit};

  always_comb begin
    rep_inc = 8'd1;
    if (rep_cnt_q != 8'd0 && trng_in == last_bit_q)
      rep_inc = (rep_cnt_q == REP_MAX) ? REP_MAX : rep_cnt_q + 8'd1;
  end

  trng_vn_debias u_debias (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (db_clr),
    .sample_i (sample),
    .bit_i    (trng_in),
    .emit_o   (db_emit),
    .bit_o    (db_bit)
  );

  always_comb begin
    state_d      = state_q;
    health_d     = health_q;
    data_d       = data_q;
    valid_d      = valid_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    warm_cnt_d   = warm_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    last_bit_d   = last_bit_q;

    // Output handoff runs in every state so a retained word can still drain.
    if (valid_q && ready_i) valid_d = 1'b0;
    if (hold_valid_q && out_free) begin
      data_d       = hold_q;
      valid_d      = 1'b1;
      hold_valid_d = 1'b0;
    end

    if (db_emit) begin
      if (bit_cnt_q == LAST_BIT) begin
        shift_d   = '0;
        bit_cnt_d = '0;
        if (out_free) begin
          data_d  = word;
          valid_d = 1'b1;
        end else begin
          hold_d       = word;
          hold_valid_d = 1'b1;
        end
      end else begin
        shift_d   = word;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    if (active) begin
      rep_cnt_d  = rep_inc;
      last_bit_d = trng_in;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_WARMUP;
          warm_cnt_d = '0;
        end
      end
      ST_WARMUP, ST_COLLECT: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          shift_d   = '0;
          bit_cnt_d = '0;
          rep_cnt_d = '0;
        end else if (rep_trip) begin
          // A tripped source invalidates everything collected, including the held word.
          state_d      = ST_FAIL;
          health_d     = 1'b1;
          data_d       = data_q;
          valid_d      = 1'b0;
          hold_valid_d = 1'b0;
          shift_d      = '0;
          bit_cnt_d    = '0;
          rep_cnt_d    = '0;
        end else if (state_q == ST_WARMUP) begin
          if (warm_done) state_d = ST_COLLECT;
          else           warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
      end
      ST_FAIL: begin
        if (clear_fail) begin
          health_d   = 1'b0;
          warm_cnt_d = '0;
          state_d    = enable ? ST_WARMUP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign trng_en_d = (state_d == ST_WARMUP) || (state_d == ST_COLLECT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      trng_en_q    <= 1'b0;
      health_q     <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      warm_cnt_q   <= '0;
      rep_cnt_q    <= '0;
      last_bit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      trng_en_q    <= trng_en_d;
      health_q     <= health_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      warm_cnt_q   <= warm_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      last_bit_q   <= last_bit_d;
    end
  end

  assign trng_en     = trng_en_q;
  assign health_fail = health_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;

endmodule
